card_dealer: RTL and testbench

//  Upstream deck source for game_fsm: on request, builds a 52-card deck and

---
 rtl/card_dealer.sv | 165 ++++++++++++++++
 tb/tb_card_dealer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/card_dealer.sv
// card_dealer: builds a 52-card deck, Fisher-Yates shuffles it from a
// free-running LFSR, then deals one card per request. DEALER_FIXED_DECK_EN skips the shuffle.
module card_dealer #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          DECK_SIZE = 52
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       shuffle_start,
  input  logic       deal_req,
  output logic       deal_valid,
  output logic [5:0] card,
  output logic [3:0] rank,
  output logic [1:0] suit,
  output logic [5:0] cards_left,
  output logic       deck_ready,
  output logic       deck_empty,
  output logic       shuffle_done
);

  localparam logic [5:0]  LAST = 6'(DECK_SIZE - 1);
  localparam logic [5:0]  FULL = 6'(DECK_SIZE);
  localparam logic [15:0] SEED =
    (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    SHUFFLE,
    READY
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [5:0]  idx_q, idx_d;
  logic [5:0]  ptr_q, ptr_d;
  logic [5:0]  card_q, card_d;
  logic [5:0]  left_q, left_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;
  logic [5:0]  deck_q [DECK_SIZE];
  logic [5:0]  deck_d [DECK_SIZE];

  logic [21:0] prod;
  logic [5:0]  j;
  logic [5:0]  base;

  // Scale the LFSR into 0..i: j = (lfsr * (i+1)) >> 16
  assign prod = 22'(lfsr_q) * 22'(idx_q + 6'd1);
  assign j    = 6'(prod >> 16);

  // Next-state, datapath and deck updates
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    card_d  = card_q;
    left_d  = left_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    deck_d  = deck_q;
    lfsr_d  = lfsr_q[0] ? ({1'b0, lfsr_q[15:1]} ^ 16'hB400)
                        : {1'b0, lfsr_q[15:1]};
    unique case (state_q)
      IDLE: begin
        if (shuffle_start) begin
          state_d = INIT;
          idx_d   = 6'd0;
        end
      end
      INIT: begin
        deck_d[idx_q] = idx_q;
        if (idx_q == LAST) begin
`ifdef DEALER_FIXED_DECK_EN
          state_d = READY;
          ptr_d   = 6'd0;
          left_d  = FULL;
          done_d  = 1'b1;
`else
          state_d = SHUFFLE;
          idx_d   = LAST;
`endif
        end else begin
          idx_d = idx_q + 6'd1;
        end
      end
      SHUFFLE: begin
        deck_d[idx_q] = deck_q[j];
        deck_d[j]     = deck_q[idx_q];
        idx_d         = idx_q - 6'd1;
        if (idx_q == 6'd1) begin
          state_d = READY;
          ptr_d   = 6'd0;
          left_d  = FULL;
          done_d  = 1'b1;
        end
      end
      READY: begin
        if (shuffle_start) begin
          state_d = INIT;
          idx_d   = 6'd0;
          left_d  = 6'd0;
        end else if (deal_req && left_q != 6'd0) begin
          card_d  = deck_q[ptr_q];
          valid_d = 1'b1;
          ptr_d   = ptr_q + 6'd1;
          left_d  = left_q - 6'd1;
        end
      end
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      lfsr_q  <= SEED;
      idx_q   <= 6'd0;
      ptr_q   <= 6'd0;
      card_q  <= 6'd0;
      left_q  <= 6'd0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      card_q  <= card_d;
      left_q  <= left_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Deck storage, contents meaningless until INIT rewrites it
  always_ff @(posedge clk) begin
    deck_q <= deck_d;
  end

  // Split card id into suit (id/13) and rank (id%13)
  always_comb begin
    suit = 2'd0;
    base = 6'd0;
    if (card_q >= 6'd39) begin
      suit = 2'd3;
      base = 6'd39;
    end else if (card_q >= 6'd26) begin
      suit = 2'd2;
      base = 6'd26;
    end else if (card_q >= 6'd13) begin
      suit = 2'd1;
      base = 6'd13;
    end
    rank = 4'(card_q - base);
  end

  assign deal_valid   = valid_q;
  assign card         = card_q;
  assign cards_left   = left_q;
  assign deck_ready   = (state_q == READY);
  assign deck_empty   = (state_q == READY) && (left_q == 6'd0);
  assign shuffle_done = done_q;

endmodule

// File: tb/tb_card_dealer.sv
// tb_card_dealer: random-timed shuffles and deals checked against
// a Fisher-Yates reference built from the LFSR sequence.
module tb_card_dealer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       shuffle_start = 1'b0;
  logic       deal_req = 1'b0;
  logic       deal_valid;
  logic [5:0] card;
  logic [3:0] rank;
  logic [1:0] suit;
  logic [5:0] cards_left;
  logic       deck_ready;
  logic       deck_empty;
  logic       shuffle_done;

`ifdef DEALER_FIXED_DECK_EN
  localparam int LAT = 52;
`else
  localparam int LAT = 103;
`endif

  card_dealer dut (
    .clk(clk),
    .reset(reset),
    .shuffle_start(shuffle_start),
    .deal_req(deal_req),
    .deal_valid(deal_valid),
    .card(card),
    .rank(rank),
    .suit(suit),
    .cards_left(cards_left),
    .deck_ready(deck_ready),
    .deck_empty(deck_empty),
    .shuffle_done(shuffle_done)
  );

  always #5 clk = ~clk;

  // edges since reset release; index k sees LFSR = seed stepped k times
  int ecnt;
  always @(posedge clk or posedge reset) begin
    if (reset) ecnt <= 0;
    else ecnt <= ecnt + 1;
  end

  int checks = 0;
  int errors = 0;
  int mdeck[52];
  int mdeck_a[52];
  int order[52];
  int order_a[52];
  int mptr, mleft, mlast;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] lfsr_at(input int n);
    logic [15:0] l;
    l = 16'hACE1;
    for (int k = 0; k < n; k++)
      l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    return l;
  endfunction

  // reference deck for a shuffle whose start was sampled at edge s
  task automatic model(input int s);
    logic [15:0] l;
    int jj, t;
    for (int k = 0; k < 52; k++) mdeck[k] = k;
`ifndef DEALER_FIXED_DECK_EN
    for (int i = 51; i >= 1; i--) begin
      l  = lfsr_at(s + 53 + (51 - i));
      jj = int'((longint'(l) * longint'(i + 1)) >> 16);
      t = mdeck[i];
      mdeck[i] = mdeck[jj];
      mdeck[jj] = t;
    end
`endif
  endtask

  task automatic start_shuffle(input int gap, input bit mid,
                               input bit req_too);
    int s, n, early;
    repeat (gap) tick();
    s = ecnt;
    model(s);
    shuffle_start = 1'b1;
    deal_req = req_too;
    tick();
    shuffle_start = 1'b0;
    deal_req = 1'b0;
    if (req_too) begin
      chk("clash_valid", deal_valid, 0);
      chk("clash_ready", deck_ready, 0);
      chk("clash_left", cards_left, 0);
      chk("clash_card", card, mlast);
    end
    n = 0;
    early = 0;
    while (shuffle_done !== 1'b1 && n < 200) begin
      if (mid && (n == 10 || n == 70)) shuffle_start = 1'b1;
      tick();
      shuffle_start = 1'b0;
      n++;
      if (shuffle_done !== 1'b1 && deck_ready === 1'b1) early++;
    end
    chk("latency", n, LAT);
    chk("early_ready", early, 0);
    chk("ready_at_done", deck_ready, 1);
    chk("left_full", cards_left, 52);
    chk("not_empty", deck_empty, 0);
    tick();
    chk("done_single", shuffle_done, 0);
    chk("ready_held", deck_ready, 1);
    mptr = 0;
    mleft = 52;
  endtask

  task automatic deal_n(input int target, input bit rnd, input bit extra);
    int budget;
    bit r;
    budget = 0;
    while (mptr < target && budget < 500) begin
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      deal_req = r;
      tick();
      budget++;
      if (r && mleft > 0) begin
        mlast = mdeck[mptr];
        order[mptr] = int'(card);
        mptr++;
        mleft--;
        chk("deal_valid", deal_valid, 1);
      end else begin
        chk("idle_valid", deal_valid, 0);
      end
      chk("card", card, mlast);
      chk("suit", suit, mlast / 13);
      chk("rank", rank, mlast % 13);
      chk("cards_left", cards_left, mleft);
    end
    deal_req = 1'b0;
    chk("deal_count", mptr, target);
    if (extra) begin
      deal_req = 1'b1;
      tick();
      deal_req = 1'b0;
      chk("extra_valid", deal_valid, 0);
      chk("empty", deck_empty, 1);
      chk("left_zero", cards_left, 0);
      chk("card_hold", card, mlast);
    end
  endtask

  task automatic perm_check();
    bit seen[52];
    int distinct;
    distinct = 0;
    for (int k = 0; k < 52; k++) seen[k] = 1'b0;
    for (int k = 0; k < 52; k++)
      if (order[k] < 52 && !seen[order[k]]) begin
        seen[order[k]] = 1'b1;
        distinct++;
      end
    chk("permutation", distinct, 52);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    mlast = 0;
  endtask

  initial begin
    int same, dut_diff, mod_diff;
    mlast = 0;
    tick();
    tick();
    chk("rst_valid", deal_valid, 0);
    chk("rst_ready", deck_ready, 0);
    chk("rst_empty", deck_empty, 0);
    chk("rst_left", cards_left, 0);
    chk("rst_card", card, 0);
    chk("rst_done", shuffle_done, 0);
    reset = 1'b0;

    // deal before any shuffle is ignored
    deal_req = 1'b1;
    tick();
    deal_req = 1'b0;
    chk("idle_deal", deal_valid, 0);

    // full shuffle, back-to-back deal of all 52 plus one extra
    start_shuffle($urandom_range(0, 15), 1'b0, 1'b0);
    deal_n(52, 1'b0, 1'b1);
    perm_check();

    // restarts during INIT/SHUFFLE do not move the ready edge
    start_shuffle($urandom_range(0, 15), 1'b1, 1'b0);
    deal_n(52, 1'b1, 1'b1);
    perm_check();

    // reset in the middle of a shuffle
    shuffle_start = 1'b1;
    tick();
    shuffle_start = 1'b0;
    repeat (73) tick();
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_ready", deck_ready, 0);
    chk("mid_rst_left", cards_left, 0);
    chk("mid_rst_card", card, 0);
    chk("mid_rst_valid", deal_valid, 0);
    chk("mid_rst_done", shuffle_done, 0);
    tick();
    tick();
    reset = 1'b0;
    mlast = 0;
    start_shuffle($urandom_range(0, 15), 1'b0, 1'b0);
    deal_n(52, 1'b1, 1'b1);
    perm_check();

    // shuffle_start beats deal_req with 40 cards left
    start_shuffle($urandom_range(0, 5), 1'b0, 1'b0);
    deal_n(12, 1'b1, 1'b0);
    chk("left_40", cards_left, 40);
    start_shuffle(0, 1'b0, 1'b1);
    deal_n(52, 1'b0, 1'b1);
    perm_check();

    // same offset from reset repeats; a different offset reorders
    do_reset();
    start_shuffle(7, 1'b0, 1'b0);
    deal_n(52, 1'b0, 1'b0);
    order_a = order;
    mdeck_a = mdeck;
    do_reset();
    start_shuffle(7, 1'b0, 1'b0);
    deal_n(52, 1'b0, 1'b0);
    same = 0;
    for (int k = 0; k < 52; k++) if (order[k] == order_a[k]) same++;
    chk("same_offset", same, 52);
    do_reset();
    start_shuffle(8, 1'b0, 1'b0);
    deal_n(52, 1'b0, 1'b0);
    dut_diff = 0;
    mod_diff = 0;
    for (int k = 0; k < 52; k++) begin
      if (order[k] != order_a[k]) dut_diff = 1;
      if (mdeck[k] != mdeck_a[k]) mod_diff = 1;
    end
    chk("diff_offset", dut_diff, mod_diff);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
